// File: rtl/code_step_if.sv
// Handshake/bus bundle between a code generator and code_step_checker.
// The master drives the sample; the slave (checker) returns decode and status.
interface code_step_if #(
    parameter int ERR_CNT_W = 8
);
    logic                 in_valid;
    logic [6:0]           code_in;
    logic                 clr_err;
    logic [2:0]           bin_out;
    logic                 bin_valid;
    logic                 dir_up;
    logic                 code_err;
    logic                 step_err;
    logic [ERR_CNT_W-1:0] err_count;
    logic                 sticky_err;
    logic                 fault;

    modport master (
        output in_valid, code_in, clr_err,
        input  bin_out, bin_valid, dir_up, code_err, step_err,
               err_count, sticky_err, fault
    );

    modport slave (
        input  in_valid, code_in, clr_err,
        output bin_out, bin_valid, dir_up, code_err, step_err,
               err_count, sticky_err, fault
    );
endinterface

// File: rtl/code_step_checker.sv
// On-line integrity monitor for a Gray/one-hot 3-bit code stream: decodes,
// checks legality and +/-1 stepping, counts errors and latches FAULT.
module code_step_checker #(
    parameter bit USE_GRAY   = 1'b1,
    parameter int ERR_CNT_W  = 8,
    parameter int MAX_CONSEC = 3
) (
    input  logic         clk,
    input  logic         rst,
    code_step_if.slave   bus
);

    typedef enum logic [1:0] {EMPTY, TRACK, FAULT} state_t;

    state_t               state_q, state_d;
    logic [2:0]           bin_q, bin_d;
    logic                 bv_q, bv_d;
    logic                 dir_q, dir_d;
    logic                 ce_q, ce_d;
    logic                 se_q, se_d;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
    logic                 sticky_q, sticky_d;
    logic [3:0]           consec_q, consec_d;

    logic [2:0] gray_val, oh_val, val, delta;
    logic [2:0] oh_ones;
    logic       gray_ok, oh_ok, legal, err;
    logic [4:0] consec_inc;

    // Decode both encodings; the parameter picks which one is live.
    always_comb begin
        gray_val[2] = bus.code_in[2];
        gray_val[1] = bus.code_in[2] ^ bus.code_in[1];
        gray_val[0] = gray_val[1] ^ bus.code_in[0];
        gray_ok     = (bus.code_in[6:3] == 4'd0);
        oh_val      = 3'd0;
        oh_ones     = 3'd0;
        for (int i = 0; i < 7; i++) begin
            if (bus.code_in[i]) begin
                oh_ones = oh_ones + 3'd1;
                oh_val  = 3'(i + 1);
            end
        end
        oh_ok = (oh_ones <= 3'd1);
        val   = USE_GRAY ? gray_val : oh_val;
        legal = USE_GRAY ? gray_ok  : oh_ok;
        delta = val - bin_q;
    end

    assign consec_inc = {1'b0, consec_q} + 5'd1;

    always_comb begin
        state_d  = state_q;
        bin_d    = bin_q;
        bv_d     = 1'b0;
        dir_d    = dir_q;
        ce_d     = 1'b0;
        se_d     = 1'b0;
        cnt_d    = cnt_q;
        sticky_d = sticky_q;
        consec_d = consec_q;
        err      = 1'b0;

        if (state_q == FAULT) begin
            // Samples are ignored here; only clr_err gets us out.
            if (bus.clr_err) begin
                state_d  = EMPTY;
                cnt_d    = '0;
                sticky_d = 1'b0;
                consec_d = 4'd0;
            end
        end else begin
            if (bus.in_valid) begin
                if (!legal) begin
                    ce_d = 1'b1;
                    err  = 1'b1;
                end else begin
                    bin_d = val;
                    bv_d  = 1'b1;
                    if (state_q == EMPTY) begin
                        state_d = TRACK;
                    end else begin
                        unique case (delta)
                            3'd0:    ;
                            3'd1:    dir_d = 1'b1;
                            3'd7:    dir_d = 1'b0;
                            default: begin
                                se_d = 1'b1;
                                err  = 1'b1;
                            end
                        endcase
                    end
                end

                if (err) begin
                    cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                    sticky_d = 1'b1;
                    consec_d = consec_inc[3:0];
                    if (consec_inc >= 5'(MAX_CONSEC) && !bus.clr_err)
                        state_d = FAULT;
                end else begin
                    consec_d = 4'd0;
                end
            end

            // Clear wins over a coincident error; the pulse still goes out.
            if (bus.clr_err) begin
                cnt_d    = '0;
                sticky_d = 1'b0;
                consec_d = 4'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            bin_q    <= 3'd0;
            bv_q     <= 1'b0;
            dir_q    <= 1'b1;
            ce_q     <= 1'b0;
            se_q     <= 1'b0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            consec_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            bin_q    <= bin_d;
            bv_q     <= bv_d;
            dir_q    <= dir_d;
            ce_q     <= ce_d;
            se_q     <= se_d;
            cnt_q    <= cnt_d;
            sticky_q <= sticky_d;
            consec_q <= consec_d;
        end
    end

    assign bus.bin_out    = bin_q;
    assign bus.bin_valid  = bv_q;
    assign bus.dir_up     = dir_q;
    assign bus.code_err   = ce_q;
    assign bus.step_err   = se_q;
    assign bus.err_count  = cnt_q;
    assign bus.sticky_err = sticky_q;
    assign bus.fault      = (state_q == FAULT);

endmodule

// File: tb/tb_code_step_checker.sv
// Directed bench for code_step_checker: Gray (W=8), one-hot (W=8) and a
// narrow-counter Gray instance share one clock and reset.
module tb_code_step_checker;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    code_step_if #(.ERR_CNT_W(8)) g_if ();
    code_step_if #(.ERR_CNT_W(8)) o_if ();
    code_step_if #(.ERR_CNT_W(2)) s_if ();

    code_step_checker #(.USE_GRAY(1'b1), .ERR_CNT_W(8), .MAX_CONSEC(3)) dut_g (
        .clk(clk), .rst(rst), .bus(g_if.slave));
    code_step_checker #(.USE_GRAY(1'b0), .ERR_CNT_W(8), .MAX_CONSEC(3)) dut_o (
        .clk(clk), .rst(rst), .bus(o_if.slave));
    code_step_checker #(.USE_GRAY(1'b1), .ERR_CNT_W(2), .MAX_CONSEC(3)) dut_s (
        .clk(clk), .rst(rst), .bus(s_if.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flags packed as {bin_valid, dir_up, code_err, step_err, sticky_err, fault}
    task automatic drive_g(input logic v, input logic [6:0] c, input logic clr);
        g_if.in_valid = v; g_if.code_in = c; g_if.clr_err = clr;
        @(posedge clk); #1;
        g_if.in_valid = 1'b0; g_if.clr_err = 1'b0;
    endtask

    task automatic drive_o(input logic v, input logic [6:0] c, input logic clr);
        o_if.in_valid = v; o_if.code_in = c; o_if.clr_err = clr;
        @(posedge clk); #1;
        o_if.in_valid = 1'b0; o_if.clr_err = 1'b0;
    endtask

    task automatic drive_s(input logic v, input logic [6:0] c, input logic clr);
        s_if.in_valid = v; s_if.code_in = c; s_if.clr_err = clr;
        @(posedge clk); #1;
        s_if.in_valid = 1'b0; s_if.clr_err = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] fl;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        fl = {g_if.bin_valid, g_if.dir_up, g_if.code_err, g_if.step_err, g_if.sticky_err, g_if.fault};
        checks++;
        if (fl !== 6'b010000 || g_if.bin_out !== 3'd0 || g_if.err_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_g flags=%b bin=%0d cnt=%0d exp flags=010000 bin=0 cnt=0", fl, g_if.bin_out, g_if.err_count);
        end
        fl = {o_if.bin_valid, o_if.dir_up, o_if.code_err, o_if.step_err, o_if.sticky_err, o_if.fault};
        checks++;
        if (fl !== 6'b010000 || o_if.err_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_o flags=%b cnt=%0d exp flags=010000 cnt=0", fl, o_if.err_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_gray_up();
        logic [6:0] codes [9];
        logic [2:0] exp_bin;
        logic [5:0] fl;
        codes = '{7'b000, 7'b001, 7'b011, 7'b010, 7'b110, 7'b111, 7'b101, 7'b100, 7'b000};
        for (int i = 0; i < 9; i++) begin
            exp_bin = 3'(i % 8);
            drive_g(1'b1, codes[i], 1'b0);
            fl = {g_if.bin_valid, g_if.dir_up, g_if.code_err, g_if.step_err, g_if.sticky_err, g_if.fault};
            checks++;
            if (g_if.bin_out !== exp_bin || fl !== 6'b110000) begin
                failures++;
                $display("FAIL gray_up[%0d] bin=%0d flags=%b exp bin=%0d flags=110000", i, g_if.bin_out, fl, exp_bin);
            end
        end
        checks++;
        if (g_if.err_count !== 8'd0) begin
            failures++;
            $display("FAIL gray_up_cnt got=%0d exp=0", g_if.err_count);
        end
    endtask

    task automatic test_gray_down();
        logic [6:0] codes [3];
        logic [2:0] exp_bin [3];
        codes   = '{7'b100, 7'b101, 7'b111};
        exp_bin = '{3'd7, 3'd6, 3'd5};
        for (int i = 0; i < 3; i++) begin
            drive_g(1'b1, codes[i], 1'b0);
            checks++;
            if (g_if.bin_out !== exp_bin[i] || g_if.dir_up !== 1'b0 || g_if.bin_valid !== 1'b1 || g_if.step_err !== 1'b0) begin
                failures++;
                $display("FAIL gray_down[%0d] bin=%0d dir=%b bv=%b se=%b exp bin=%0d dir=0 bv=1 se=0",
                         i, g_if.bin_out, g_if.dir_up, g_if.bin_valid, g_if.step_err, exp_bin[i]);
            end
        end
        drive_g(1'b1, 7'b0001000, 1'b0);
        checks++;
        if (g_if.code_err !== 1'b1 || g_if.bin_out !== 3'd5 || g_if.bin_valid !== 1'b0 ||
            g_if.err_count !== 8'd1 || g_if.sticky_err !== 1'b1) begin
            failures++;
            $display("FAIL gray_illegal ce=%b bin=%0d bv=%b cnt=%0d sticky=%b exp ce=1 bin=5 bv=0 cnt=1 sticky=1",
                     g_if.code_err, g_if.bin_out, g_if.bin_valid, g_if.err_count, g_if.sticky_err);
        end
        drive_g(1'b0, 7'b0, 1'b1);
        checks++;
        if (g_if.err_count !== 8'd0 || g_if.sticky_err !== 1'b0 || g_if.code_err !== 1'b0) begin
            failures++;
            $display("FAIL gray_clr cnt=%0d sticky=%b ce=%b exp 0 0 0", g_if.err_count, g_if.sticky_err, g_if.code_err);
        end
    endtask

    task automatic test_onehot();
        logic [6:0] codes [3];
        codes = '{7'b0000000, 7'b0000001, 7'b0000010};
        for (int i = 0; i < 3; i++) begin
            drive_o(1'b1, codes[i], 1'b0);
            checks++;
            if (o_if.bin_out !== 3'(i) || o_if.bin_valid !== 1'b1 || o_if.step_err !== 1'b0 || o_if.code_err !== 1'b0) begin
                failures++;
                $display("FAIL onehot[%0d] bin=%0d bv=%b se=%b ce=%b exp bin=%0d bv=1 se=0 ce=0",
                         i, o_if.bin_out, o_if.bin_valid, o_if.step_err, o_if.code_err, i);
            end
        end
        drive_o(1'b1, 7'b0100000, 1'b0);
        checks++;
        if (o_if.step_err !== 1'b1 || o_if.bin_out !== 3'd6 || o_if.bin_valid !== 1'b1 || o_if.err_count !== 8'd1) begin
            failures++;
            $display("FAIL onehot_step se=%b bin=%0d bv=%b cnt=%0d exp se=1 bin=6 bv=1 cnt=1",
                     o_if.step_err, o_if.bin_out, o_if.bin_valid, o_if.err_count);
        end
        drive_o(1'b1, 7'b0000011, 1'b0);
        checks++;
        if (o_if.code_err !== 1'b1 || o_if.bin_out !== 3'd6 || o_if.bin_valid !== 1'b0 || o_if.err_count !== 8'd2) begin
            failures++;
            $display("FAIL onehot_illegal ce=%b bin=%0d bv=%b cnt=%0d exp ce=1 bin=6 bv=0 cnt=2",
                     o_if.code_err, o_if.bin_out, o_if.bin_valid, o_if.err_count);
        end
    endtask

    task automatic test_fault();
        logic [6:0] bad [3];
        bad = '{7'b0001000, 7'b0010000, 7'b1000000};
        for (int i = 0; i < 3; i++) begin
            drive_g(1'b1, bad[i], 1'b0);
            checks++;
            if (g_if.code_err !== 1'b1 || g_if.err_count !== 8'(i + 1) || g_if.fault !== (i == 2)) begin
                failures++;
                $display("FAIL fault_seq[%0d] ce=%b cnt=%0d fault=%b exp ce=1 cnt=%0d fault=%b",
                         i, g_if.code_err, g_if.err_count, g_if.fault, i + 1, (i == 2));
            end
        end
        drive_g(1'b1, 7'b0001000, 1'b0);
        checks++;
        if (g_if.code_err !== 1'b0 || g_if.err_count !== 8'd3 || g_if.fault !== 1'b1) begin
            failures++;
            $display("FAIL fault_ignore_bad ce=%b cnt=%0d fault=%b exp 0 3 1", g_if.code_err, g_if.err_count, g_if.fault);
        end
        drive_g(1'b1, 7'b100, 1'b0);
        checks++;
        if (g_if.bin_valid !== 1'b0 || g_if.bin_out !== 3'd5 || g_if.fault !== 1'b1) begin
            failures++;
            $display("FAIL fault_ignore_good bv=%b bin=%0d fault=%b exp 0 5 1", g_if.bin_valid, g_if.bin_out, g_if.fault);
        end
        drive_g(1'b0, 7'b0, 1'b1);
        checks++;
        if (g_if.fault !== 1'b0 || g_if.err_count !== 8'd0 || g_if.sticky_err !== 1'b0) begin
            failures++;
            $display("FAIL fault_clr fault=%b cnt=%0d sticky=%b exp 0 0 0", g_if.fault, g_if.err_count, g_if.sticky_err);
        end
        // 5 -> 0 would be a step error in TRACK; from EMPTY it just loads
        drive_g(1'b1, 7'b000, 1'b0);
        checks++;
        if (g_if.bin_valid !== 1'b1 || g_if.step_err !== 1'b0 || g_if.bin_out !== 3'd0 || g_if.err_count !== 8'd0) begin
            failures++;
            $display("FAIL fault_reload bv=%b se=%b bin=%0d cnt=%0d exp 1 0 0 0",
                     g_if.bin_valid, g_if.step_err, g_if.bin_out, g_if.err_count);
        end
    endtask

    task automatic test_saturate();
        int         v;
        logic [1:0] exp_cnt;
        drive_s(1'b1, 7'b000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            exp_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
            drive_s(1'b1, 7'b0001000, 1'b0);
            checks++;
            if (s_if.code_err !== 1'b1 || s_if.err_count !== exp_cnt || s_if.fault !== 1'b0) begin
                failures++;
                $display("FAIL sat_err[%0d] ce=%b cnt=%0d fault=%b exp ce=1 cnt=%0d fault=0",
                         i, s_if.code_err, s_if.err_count, s_if.fault, exp_cnt);
            end
            v = i + 1;
            drive_s(1'b1, 7'(v ^ (v >> 1)), 1'b0);
            checks++;
            if (s_if.bin_out !== 3'(v) || s_if.step_err !== 1'b0 || s_if.dir_up !== 1'b1) begin
                failures++;
                $display("FAIL sat_good[%0d] bin=%0d se=%b dir=%b exp bin=%0d se=0 dir=1",
                         i, s_if.bin_out, s_if.step_err, s_if.dir_up, v);
            end
        end
        drive_s(1'b1, 7'b0010000, 1'b1);
        checks++;
        if (s_if.code_err !== 1'b1 || s_if.err_count !== 2'd0 || s_if.sticky_err !== 1'b0) begin
            failures++;
            $display("FAIL sat_clr_coincident ce=%b cnt=%0d sticky=%b exp 1 0 0", s_if.code_err, s_if.err_count, s_if.sticky_err);
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] fl;
        drive_g(1'b1, 7'b0001000, 1'b0);
        rst = 1'b1;
        g_if.in_valid = 1'b1; g_if.code_in = 7'b011; g_if.clr_err = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        g_if.in_valid = 1'b0;
        fl = {g_if.bin_valid, g_if.dir_up, g_if.code_err, g_if.step_err, g_if.sticky_err, g_if.fault};
        checks++;
        if (fl !== 6'b010000 || g_if.bin_out !== 3'd0 || g_if.err_count !== 8'd0) begin
            failures++;
            $display("FAIL reset_mid flags=%b bin=%0d cnt=%0d exp flags=010000 bin=0 cnt=0", fl, g_if.bin_out, g_if.err_count);
        end
        drive_g(1'b1, 7'b110, 1'b0);
        checks++;
        if (g_if.bin_valid !== 1'b1 || g_if.step_err !== 1'b0 || g_if.bin_out !== 3'd4) begin
            failures++;
            $display("FAIL reset_reload bv=%b se=%b bin=%0d exp 1 0 4", g_if.bin_valid, g_if.step_err, g_if.bin_out);
        end
        drive_g(1'b1, 7'b010, 1'b0);
        checks++;
        if (g_if.bin_out !== 3'd3 || g_if.dir_up !== 1'b0 || g_if.step_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_track bin=%0d dir=%b se=%b exp 3 0 0", g_if.bin_out, g_if.dir_up, g_if.step_err);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0;
        g_if.in_valid = 1'b0; g_if.code_in = 7'b0; g_if.clr_err = 1'b0;
        o_if.in_valid = 1'b0; o_if.code_in = 7'b0; o_if.clr_err = 1'b0;
        s_if.in_valid = 1'b0; s_if.code_in = 7'b0; s_if.clr_err = 1'b0;
        test_reset();
        test_gray_up();
        test_gray_down();
        test_onehot();
        test_fault();
        test_saturate();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
